// File: rtl/lcd_i2c_pkg.sv
// Shared definitions for the HD44780-over-PCF8574 sequencer: port bit map,
// FSM states, init tables and delay times.
package lcd_i2c_pkg;

  localparam int unsigned CNT_W = 32;

  // PCF8574 port bit positions
  localparam int unsigned P_RS  = 0;
  localparam int unsigned P_RW  = 1;
  localparam int unsigned P_EN  = 2;
  localparam int unsigned P_BL  = 3;
  localparam int unsigned P_NIB = 4;

  localparam int unsigned T_PWRUP_US = 50_000;
  localparam int unsigned T_INIT0_US = 5_000;
  localparam int unsigned T_INIT_US  = 200;
  localparam int unsigned T_CMD_US   = 50;
  localparam int unsigned T_LONG_US  = 2_000;

  typedef enum logic [2:0] {
    PWRUP, INIT_NIB, INIT_BYTE, IDLE, WR_REQ, WR_WAIT_HI, WR_WAIT_LO, DELAY
  } state_e;

  // What the write engine returns to once a nibble/byte and its delay are done
  typedef enum logic [1:0] {PH_NIB, PH_BYTE, PH_USER} phase_e;

  function automatic logic [3:0] init_nib(input logic [1:0] idx);
    return (idx == 2'd3) ? 4'h2 : 4'h3;
  endfunction

  function automatic logic [7:0] init_cmd(input logic [1:0] idx);
    logic [7:0] w_cmd;
    unique case (idx)
      2'd0:    w_cmd = 8'h28;
      2'd1:    w_cmd = 8'h0C;
      2'd2:    w_cmd = 8'h06;
      default: w_cmd = 8'h01;
    endcase
    return w_cmd;
  endfunction

  function automatic logic [CNT_W-1:0] us_to_cyc(input int unsigned us, input int unsigned clk_hz);
    return CNT_W'((64'(us) * 64'(clk_hz)) / 64'd1_000_000);
  endfunction

  function automatic logic [7:0] port_byte(input logic [3:0] nib, input logic en,
                                           input logic rs, input logic bl);
    logic [7:0] w_b;
    w_b              = '0;
    w_b[P_NIB +: 4]  = nib;
    w_b[P_BL]        = bl;
    w_b[P_EN]        = en;
    w_b[P_RW]        = 1'b0;
    w_b[P_RS]        = rs;
    return w_b;
  endfunction

endpackage

// File: rtl/lcd_delay_counter.sv
// Saturating up-counter used for every wait; done once the latched target is reached.
module lcd_delay_counter
  import lcd_i2c_pkg::*;
#(
  parameter logic [CNT_W-1:0] RST_TARGET = '0
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_load,
  input  logic             i_count,
  input  logic [CNT_W-1:0] i_target,
  output logic             o_done_c
);

  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] r_target;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt    <= '0;
      r_target <= RST_TARGET;
    end else if (i_load) begin
      r_cnt    <= '0;
      r_target <= i_target;
    end else if (i_count && (r_cnt < r_target)) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign o_done_c = (r_cnt >= r_target);

endmodule

// File: rtl/lcd_i2c_sequencer.sv
// Drives an HD44780 LCD through a PCF8574 I2C expander: power-up wait, 4-bit
// init sequence, then host bytes as nibble pairs with EN strobes.
module lcd_i2c_sequencer
  import lcd_i2c_pkg::*;
#(
  parameter int unsigned CLK_HZ    = 100_000_000,
  parameter bit          BACKLIGHT = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       req_rs,
  input  logic [7:0] req_data,
  output logic       init_done,
  output logic       i2c_ena,
  output logic [7:0] i2c_data,
  input  logic       i2c_busy,
  input  logic       i2c_ack_error,
  output logic       err
);

  localparam logic [CNT_W-1:0] C_PWRUP = us_to_cyc(T_PWRUP_US, CLK_HZ);
  localparam logic [CNT_W-1:0] C_INIT0 = us_to_cyc(T_INIT0_US, CLK_HZ);
  localparam logic [CNT_W-1:0] C_INIT  = us_to_cyc(T_INIT_US, CLK_HZ);
  localparam logic [CNT_W-1:0] C_CMD   = us_to_cyc(T_CMD_US, CLK_HZ);
  localparam logic [CNT_W-1:0] C_LONG  = us_to_cyc(T_LONG_US, CLK_HZ);

  state_e           r_state, w_state_nxt;
  phase_e           r_phase, w_phase_nxt;
  logic [1:0]       r_item, w_item_nxt;
  logic [1:0]       r_idx, w_idx_nxt;
  logic [7:0]       r_byte, w_byte_nxt;
  logic             r_rs, w_rs_nxt;
  logic             r_ena, w_ena_nxt;
  logic [7:0]       r_data, w_data_nxt;
  logic             r_init_done, w_init_done_nxt;
  logic             r_err, w_err_nxt;
  logic             w_load, w_count, w_done, w_ready;
  logic [1:0]       w_last_idx;
  logic [CNT_W-1:0] w_delay;

  lcd_delay_counter #(.RST_TARGET(C_PWRUP)) u_delay (
    .i_clk    (clk),
    .i_rst    (rst),
    .i_load   (w_load),
    .i_count  (w_count),
    .i_target (w_delay),
    .o_done_c (w_done)
  );

  assign w_ready    = (r_state == IDLE) && r_init_done;
  assign w_count    = (r_state == PWRUP) || (r_state == DELAY);
  assign w_last_idx = (r_phase == PH_NIB) ? 2'd1 : 2'd3;

  // Wait that follows the nibble/byte currently being written
  always_comb begin
    w_delay = C_CMD;
    unique case (r_phase)
      PH_NIB:  w_delay = (r_item == 2'd0) ? C_INIT0 : C_INIT;
      PH_BYTE: w_delay = (r_item == 2'd3) ? C_LONG : C_CMD;
      default: w_delay = (!r_rs && ((r_byte == 8'h01) || (r_byte == 8'h02))) ? C_LONG : C_CMD;
    endcase
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_phase_nxt     = r_phase;
    w_item_nxt      = r_item;
    w_idx_nxt       = r_idx;
    w_byte_nxt      = r_byte;
    w_rs_nxt        = r_rs;
    w_ena_nxt       = r_ena;
    w_data_nxt      = r_data;
    w_init_done_nxt = r_init_done;
    w_err_nxt       = r_err;
    w_load          = 1'b0;
    unique case (r_state)
      PWRUP: if (w_done) begin
        w_item_nxt  = 2'd0;
        w_state_nxt = INIT_NIB;
      end
      INIT_NIB: begin
        w_phase_nxt = PH_NIB;
        w_byte_nxt  = {init_nib(r_item), 4'h0};
        w_rs_nxt    = 1'b0;
        w_idx_nxt   = 2'd0;
        w_state_nxt = WR_REQ;
      end
      INIT_BYTE: begin
        w_phase_nxt = PH_BYTE;
        w_byte_nxt  = init_cmd(r_item);
        w_rs_nxt    = 1'b0;
        w_idx_nxt   = 2'd0;
        w_state_nxt = WR_REQ;
      end
      IDLE: if (req_valid && w_ready) begin
        w_phase_nxt = PH_USER;
        w_byte_nxt  = req_data;
        w_rs_nxt    = req_rs;
        w_idx_nxt   = 2'd0;
        w_state_nxt = WR_REQ;
      end
      WR_REQ: if (!i2c_busy) begin
        w_ena_nxt   = 1'b1;
        w_state_nxt = WR_WAIT_HI;
      end
      WR_WAIT_HI: if (i2c_busy) begin
        w_ena_nxt   = 1'b0;
        w_state_nxt = WR_WAIT_LO;
      end
      WR_WAIT_LO: if (!i2c_busy) begin
        if (i2c_ack_error) w_err_nxt = 1'b1;
        if (r_idx == w_last_idx) begin
          w_load      = 1'b1;
          w_state_nxt = DELAY;
        end else begin
          w_idx_nxt   = r_idx + 2'd1;
          w_state_nxt = WR_REQ;
        end
      end
      DELAY: if (w_done) begin
        unique case (r_phase)
          PH_NIB: begin
            w_item_nxt  = r_item + 2'd1;
            w_state_nxt = (r_item == 2'd3) ? INIT_BYTE : INIT_NIB;
          end
          PH_BYTE: begin
            w_item_nxt = r_item + 2'd1;
            if (r_item == 2'd3) begin
              w_init_done_nxt = 1'b1;
              w_state_nxt     = IDLE;
            end else begin
              w_state_nxt = INIT_BYTE;
            end
          end
          default: w_state_nxt = IDLE;
        endcase
      end
      default: w_state_nxt = PWRUP;
    endcase
    // Port byte only changes on entry to WR_REQ, when ena and busy are both low
    if ((w_state_nxt == WR_REQ) && (r_state != WR_REQ)) begin
      w_data_nxt = port_byte(w_idx_nxt[1] ? w_byte_nxt[3:0] : w_byte_nxt[7:4],
                             ~w_idx_nxt[0], w_rs_nxt, BACKLIGHT);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= PWRUP;
      r_phase     <= PH_NIB;
      r_item      <= 2'd0;
      r_idx       <= 2'd0;
      r_byte      <= 8'h00;
      r_rs        <= 1'b0;
      r_ena       <= 1'b0;
      r_data      <= port_byte(4'h0, 1'b0, 1'b0, BACKLIGHT);
      r_init_done <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_phase     <= w_phase_nxt;
      r_item      <= w_item_nxt;
      r_idx       <= w_idx_nxt;
      r_byte      <= w_byte_nxt;
      r_rs        <= w_rs_nxt;
      r_ena       <= w_ena_nxt;
      r_data      <= w_data_nxt;
      r_init_done <= w_init_done_nxt;
      r_err       <= w_err_nxt;
    end
  end

  assign req_ready = w_ready;
  assign i2c_ena   = r_ena;
  assign i2c_data  = r_data;
  assign init_done = r_init_done;
  assign err       = r_err;

endmodule

// File: tb/tb_lcd_i2c_sequencer.sv
// Scoreboard bench for lcd_i2c_sequencer with a behavioural I2C master
// (busy rises 3 cycles after ena and lasts 20 cycles).
module tb_lcd_i2c_sequencer;

  localparam int unsigned CLK_HZ_TB = 400_000;
  localparam int C_PWRUP = int'(CLK_HZ_TB / 20);
  localparam int C_CMD   = int'(50 * CLK_HZ_TB / 1_000_000);
  localparam int C_LONG  = int'(2000 * CLK_HZ_TB / 1_000_000);
  localparam logic [7:0] INIT_STREAM [24] = '{
    8'h3C, 8'h38, 8'h3C, 8'h38, 8'h3C, 8'h38, 8'h2C, 8'h28,
    8'h2C, 8'h28, 8'h8C, 8'h88, 8'h0C, 8'h08, 8'hCC, 8'hC8,
    8'h0C, 8'h08, 8'h6C, 8'h68, 8'h0C, 8'h08, 8'h1C, 8'h18};

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req_valid = 1'b0;
  logic       req_rs = 1'b0;
  logic [7:0] req_data = 8'h00;
  logic       i2c_busy, i2c_ack_error;
  logic       req_ready, init_done, i2c_ena, err;
  logic [7:0] i2c_data;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int wr_count = 0;
  int err_idx = -1;
  int last_fall_cyc = 0;
  logic [7:0] exp_q[$];

  lcd_i2c_sequencer #(.CLK_HZ(CLK_HZ_TB), .BACKLIGHT(1'b1)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_rs(req_rs), .req_data(req_data), .init_done(init_done),
    .i2c_ena(i2c_ena), .i2c_data(i2c_data), .i2c_busy(i2c_busy),
    .i2c_ack_error(i2c_ack_error), .err(err));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_range(input string name, input int act, input int lo, input int hi);
    tests++;
    if (act < lo || act > hi) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  function automatic logic sel(input int which);
    case (which)
      0:       return i2c_ena;
      1:       return init_done;
      default: return req_ready;
    endcase
  endfunction

  task automatic wait_sig(input int which, input int bound, output int at);
    bit found = 0;
    at = 0;
    for (int k = 0; k < bound && !found; k++) begin
      @(negedge clk);
      if (sel(which)) begin
        found = 1;
        at = cyc;
      end
    end
    if (!found) begin
      tests++;
      fails++;
      at = cyc;
      $display("FAIL timeout waiting on signal %0d after %0d cycles", which, bound);
    end
  endtask

  // Behavioural I2C master; abandons any transaction while rst is high
  initial begin
    int m_st;
    int m_cnt;
    m_st = 0;
    m_cnt = 0;
    i2c_busy = 1'b0;
    i2c_ack_error = 1'b0;
    forever begin
      @(negedge clk);
      i2c_ack_error = 1'b0;
      if (rst) begin
        m_st = 0;
        i2c_busy = 1'b0;
      end else begin
        case (m_st)
          0: if (i2c_ena) begin m_st = 1; m_cnt = 2; end
          1: begin
            m_cnt--;
            if (m_cnt == 0) begin i2c_busy = 1'b1; m_cnt = 20; m_st = 2; end
          end
          default: begin
            m_cnt--;
            if (m_cnt == 0) begin
              i2c_busy = 1'b0;
              i2c_ack_error = (wr_count == err_idx);
              wr_count++;
              last_fall_cyc = cyc;
              m_st = 0;
            end
          end
        endcase
      end
    end
  end

  // Monitor: each new write request is popped against the expected stream
  initial begin
    logic       ena_q, busy_q, stable;
    logic [7:0] cap, exp_b;
    ena_q = 1'b0; busy_q = 1'b0; stable = 1'b1; cap = 8'h00;
    forever begin
      @(posedge clk);
      #1;
      if (i2c_ena && !ena_q) begin
        check("ena_while_busy", i2c_busy, 1'b0);
        tests++;
        if (exp_q.size() == 0) begin
          fails++;
          $display("FAIL unexpected_write: got 0x%0h expected none", i2c_data);
        end else begin
          exp_b = exp_q.pop_front();
          if (i2c_data !== exp_b) begin
            fails++;
            $display("FAIL write_byte: got 0x%0h expected 0x%0h", i2c_data, exp_b);
          end
        end
        cap = i2c_data;
        stable = 1'b1;
      end else if (i2c_ena || i2c_busy) begin
        stable = stable && (i2c_data == cap);
      end
      if (busy_q && !i2c_busy && !rst) check("data_stable", stable, 1'b1);
      ena_q  = i2c_ena;
      busy_q = i2c_busy;
    end
  end

  task automatic run_init();
    int rel, at;
    for (int i = 0; i < 24; i++) exp_q.push_back(INIT_STREAM[i]);
    @(negedge clk);
    rst = 1'b0;
    rel = cyc;
    wait_sig(0, 30000, at);
    check_range("pwrup_quiet", at - rel, C_PWRUP, C_PWRUP + 6);
    wait_sig(1, 30000, at);
    check_range("init_done_lat", at - last_fall_cyc, C_LONG, C_LONG + 4);
    check("init_drained", exp_q.size(), 0);
    check("ready_after_init", req_ready, 1'b1);
  endtask

  task automatic issue(input logic rs, input logic [7:0] d);
    int at;
    wait_sig(2, 4000, at);
    req_valid = 1'b1;
    req_rs    = rs;
    req_data  = d;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_data  = 8'h00;
  endtask

  task automatic send_op(input logic rs, input logic [7:0] d, input logic [7:0] e0,
                         input logic [7:0] e1, input logic [7:0] e2, input logic [7:0] e3,
                         input int dly, input bit poke);
    int at;
    exp_q.push_back(e0); exp_q.push_back(e1); exp_q.push_back(e2); exp_q.push_back(e3);
    issue(rs, d);
    @(negedge clk);
    check("ready_drop", req_ready, 1'b0);
    if (poke) begin
      repeat (10) @(negedge clk);
      req_valid = 1'b1; req_rs = 1'b1; req_data = 8'h77;
      repeat (5) @(negedge clk);
      req_valid = 1'b0; req_data = 8'h00;
    end
    wait_sig(2, 4000, at);
    check_range("ready_lat", at - last_fall_cyc, dly, dly + 4);
    check("op_drained", exp_q.size(), 0);
  endtask

  initial begin
    int at;
    repeat (5) @(posedge clk);
    @(negedge clk);
    check("rst_ena", i2c_ena, 1'b0);
    check("rst_data", i2c_data, 8'h08);
    check("rst_init_done", init_done, 1'b0);
    check("rst_err", err, 1'b0);
    check("rst_ready", req_ready, 1'b0);

    run_init();

    send_op(1'b1, 8'h41, 8'h4D, 8'h49, 8'h1D, 8'h19, C_CMD, 1'b1);
    send_op(1'b0, 8'h01, 8'h0C, 8'h08, 8'h1C, 8'h18, C_LONG, 1'b0);
    send_op(1'b0, 8'h02, 8'h0C, 8'h08, 8'h2C, 8'h28, C_LONG, 1'b0);
    send_op(1'b1, 8'h01, 8'h0D, 8'h09, 8'h1D, 8'h19, C_CMD, 1'b0);
    send_op(1'b0, 8'h03, 8'h0C, 8'h08, 8'h3C, 8'h38, C_CMD, 1'b0);

    check("err_pre", err, 1'b0);
    err_idx = wr_count + 2;
    send_op(1'b1, 8'h5A, 8'h5D, 8'h59, 8'hAD, 8'hA9, C_CMD, 1'b0);
    check("err_set", err, 1'b1);
    err_idx = -1;
    send_op(1'b1, 8'h20, 8'h2D, 8'h29, 8'h0D, 8'h09, C_CMD, 1'b0);
    check("err_sticky", err, 1'b1);

    // Reset while the first write of a character is being requested
    exp_q.push_back(8'h4D);
    issue(1'b1, 8'h42);
    wait_sig(0, 50, at);
    rst = 1'b1;
    exp_q.delete();
    @(negedge clk);
    check("midrst_ena", i2c_ena, 1'b0);
    check("midrst_init_done", init_done, 1'b0);
    check("midrst_ready", req_ready, 1'b0);
    check("midrst_err", err, 1'b0);
    check("midrst_data", i2c_data, 8'h08);
    repeat (3) @(negedge clk);
    run_init();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
